vrf_read_rr_arbiter: RTL

//  Arbitrates NUM_IN VRF read-request sources onto a single VRF read port.

---
 rtl/vrf_read_rr_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vrf_read_rr_arbiter.sv
// Round-robin arbiter funnelling NUM_IN VRF read requests onto one read port,
// with an optional registered output stage to cut the ready/valid path.
module vrf_read_rr_arbiter #(
  parameter int NUM_IN = 4,
  parameter int VS_W   = 5,
  parameter int SRC_W  = 2,
  parameter int OFF_W  = 3,
  parameter int IDX_W  = 3,
  parameter int PIPE   = 1,
  localparam int CH_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         io_in_valid,
  output logic [NUM_IN-1:0]         io_in_ready,
  input  logic [NUM_IN*VS_W-1:0]    io_in_bits_vs,
  input  logic [NUM_IN*SRC_W-1:0]   io_in_bits_readSource,
  input  logic [NUM_IN*OFF_W-1:0]   io_in_bits_offset,
  input  logic [NUM_IN*IDX_W-1:0]   io_in_bits_instructionIndex,
  input  logic                      io_out_ready,
  output logic                      io_out_valid,
  output logic [VS_W-1:0]           io_out_bits_vs,
  output logic [SRC_W-1:0]          io_out_bits_readSource,
  output logic [OFF_W-1:0]          io_out_bits_offset,
  output logic [IDX_W-1:0]          io_out_bits_instructionIndex,
  output logic [CH_W-1:0]           io_out_chosen
);

  logic [CH_W-1:0]  ptr_q, ptr_d;
  logic [CH_W-1:0]  winner;
  logic             found;
  logic             stage_rdy;
  logic             grant;
  logic [VS_W-1:0]  sel_vs;
  logic [SRC_W-1:0] sel_src;
  logic [OFF_W-1:0] sel_off;
  logic [IDX_W-1:0] sel_idx;

  // Pass 0 looks at sources at or above ptr, pass 1 wraps around to the rest.
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    sel_vs  = '0;
    sel_src = '0;
    sel_off = '0;
    sel_idx = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!found && io_in_valid[i] && ((pass == 1) || (CH_W'(i) >= ptr_q))) begin
          found   = 1'b1;
          winner  = CH_W'(i);
          sel_vs  = io_in_bits_vs[i*VS_W +: VS_W];
          sel_src = io_in_bits_readSource[i*SRC_W +: SRC_W];
          sel_off = io_in_bits_offset[i*OFF_W +: OFF_W];
          sel_idx = io_in_bits_instructionIndex[i*IDX_W +: IDX_W];
        end
      end
    end
  end

  assign grant = reset && found && stage_rdy;

  always_comb begin
    io_in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      io_in_ready[i] = grant && (CH_W'(i) == winner);
    end
  end

  // The pointer wraps at NUM_IN, which need not be a power of two.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = (winner == CH_W'(NUM_IN - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic             out_valid_q, out_valid_d;
    logic [VS_W-1:0]  out_vs_q, out_vs_d;
    logic [SRC_W-1:0] out_src_q, out_src_d;
    logic [OFF_W-1:0] out_off_q, out_off_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [CH_W-1:0]  out_ch_q, out_ch_d;

    // Draining and reloading in the same cycle keeps one grant per cycle.
    assign stage_rdy = !out_valid_q || io_out_ready;

    always_comb begin
      out_valid_d = out_valid_q;
      out_vs_d    = out_vs_q;
      out_src_d   = out_src_q;
      out_off_d   = out_off_q;
      out_idx_d   = out_idx_q;
      out_ch_d    = out_ch_q;
      if (grant) begin
        out_valid_d = 1'b1;
        out_vs_d    = sel_vs;
        out_src_d   = sel_src;
        out_off_d   = sel_off;
        out_idx_d   = sel_idx;
        out_ch_d    = winner;
      end else if (io_out_ready) begin
        out_valid_d = 1'b0;
      end
    end

    always_ff @(posedge clock) begin
      if (!reset) begin
        out_valid_q <= 1'b0;
        out_vs_q    <= '0;
        out_src_q   <= '0;
        out_off_q   <= '0;
        out_idx_q   <= '0;
        out_ch_q    <= '0;
      end else begin
        out_valid_q <= out_valid_d;
        out_vs_q    <= out_vs_d;
        out_src_q   <= out_src_d;
        out_off_q   <= out_off_d;
        out_idx_q   <= out_idx_d;
        out_ch_q    <= out_ch_d;
      end
    end

    assign io_out_valid                 = reset && out_valid_q;
    assign io_out_bits_vs               = out_vs_q;
    assign io_out_bits_readSource       = out_src_q;
    assign io_out_bits_offset           = out_off_q;
    assign io_out_bits_instructionIndex = out_idx_q;
    assign io_out_chosen                = out_ch_q;
  end else begin : g_comb
    assign stage_rdy                    = io_out_ready;
    assign io_out_valid                 = reset && found;
    assign io_out_bits_vs               = sel_vs;
    assign io_out_bits_readSource       = sel_src;
    assign io_out_bits_offset           = sel_off;
    assign io_out_bits_instructionIndex = sel_idx;
    assign io_out_chosen                = winner;
  end

endmodule
